axis_capture_ahb: RTL and testbench

AXI-Stream sink that captures a burst of DSP samples into an internal buffer and exposes control, status and the captured samples to software over an AHB-Lite slave port. It is the receiving end of the sample streams the DSP subsystem and the stream sources in our benches produce, and is the responder for the AHB file-read master. It is used for on-chip waveform capture and for closing the loop in subsystem benches.

---
 rtl/axis_capture_ahb_if.sv | 45 ++++
 rtl/axis_capture_ahb.sv | 233 +++++++++++++++++++++++
 tb/tb_axis_capture_ahb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_capture_ahb_if.sv
// ---------------------------------------------------------------------------
// axis_capture_ahb_if
// Purpose : bundles the AXI-Stream sink signals and the AHB-Lite slave
//           signals of axis_capture_ahb.
// Params  : DW - stream sample width.
// Modports: master - stream source / bus master side (drives tdata..hsel)
//           slave  - the capture block side (drives tready, hrdata,
//                    hreadyout, hresp)
// ---------------------------------------------------------------------------
interface axis_capture_ahb_if #(
   parameter int unsigned DW = 16
);
   // AXI-Stream
   logic [DW-1:0] tdata_s;
   logic          tvalid_s;
   logic          tready_s;
   logic          tlast_s;
   logic          tuser_s;
   // AHB-Lite
   logic [31:0]   haddr_s;
   logic [1:0]    htrans_s;
   logic [2:0]    hsize_s;
   logic [2:0]    hburst_s;
   logic          hwrite_s;
   logic [31:0]   hwdata_s;
   logic          hsel_s;
   logic          hready_s;
   logic [31:0]   hrdata_s;
   logic          hreadyout_s;
   logic          hresp_s;

   modport master (
      output tdata_s, tvalid_s, tlast_s, tuser_s,
      output haddr_s, htrans_s, hsize_s, hburst_s, hwrite_s, hwdata_s,
      output hsel_s, hready_s,
      input  tready_s, hrdata_s, hreadyout_s, hresp_s
   );

   modport slave (
      input  tdata_s, tvalid_s, tlast_s, tuser_s,
      input  haddr_s, htrans_s, hsize_s, hburst_s, hwrite_s, hwdata_s,
      input  hsel_s, hready_s,
      output tready_s, hrdata_s, hreadyout_s, hresp_s
   );
endinterface

// File: rtl/axis_capture_ahb.sv
// ---------------------------------------------------------------------------
// axis_capture_ahb
// Purpose : AXI-Stream sink that captures a burst of samples into an
//           internal buffer; control, status and samples are accessed over
//           an AHB-Lite slave port.
// Ports   : hclk   - clock
//           hreset - synchronous active-high reset
//           ce     - clock enable for the capture logic (tready follows it)
//           bus    - axis_capture_ahb_if.slave (AXIS sink + AHB-Lite slave)
//           irq    - capture-done interrupt, level
// Config  : AXIS_CAPTURE_SIGNED_EN - when defined, buffer reads sign-extend
//           the DW-bit sample to 32 bits; otherwise they zero-extend.
// Map     : 0x000 CTRL (W pulses: ARM, ABORT, IRQ_CLR), 0x004 MODE,
//           0x008 STATUS, 0x00C COUNT, 0x400+4*i sample i.
// ---------------------------------------------------------------------------
module axis_capture_ahb #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 256
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              ce,
   axis_capture_ahb_if.slave bus,
   output logic              irq
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [11:0] A_CTRL   = 12'h000;
   localparam logic [11:0] A_MODE   = 12'h004;
   localparam logic [11:0] A_STATUS = 12'h008;
   localparam logic [11:0] A_COUNT  = 12'h00C;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_SYNC = 2'd1,
      S_CAPTURE   = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_count, w_count_nxt;
   logic            r_done, w_done_nxt;
   logic            r_irq, w_irq_nxt;
   logic            r_trunc, w_trunc_nxt;
   logic [1:0]      r_mode;
   logic            r_arm, r_abort, r_irq_clr;

   logic            w_tready;
   logic            w_beat;
   logic            w_wr_en;
   logic [AW-1:0]   w_wr_idx;

   logic [DW-1:0]   r_mem [DEPTH];
   logic [DW-1:0]   r_ram_q;

   logic            r_dp_valid;
   logic            r_dp_write;
   logic [11:0]     r_dp_addr;
   logic            r_rd_pend;
   logic [31:0]     r_hrdata;
   logic            r_hreadyout;

   logic            w_addr_ph;
   logic [9:0]      w_buf_off;
   logic            w_is_buf;
   logic [AW-1:0]   w_buf_idx;
   logic [31:0]     w_reg_rdata;
   logic            w_wr_ctrl;
   logic            w_unused;

   function automatic logic [31:0] ext_sample(input logic [DW-1:0] s);
`ifdef AXIS_CAPTURE_SIGNED_EN
      return 32'(signed'(s));
`else
      return 32'(s);
`endif
   endfunction

   // Sink is always ready when enabled, so the source is never stalled.
   assign w_tready = ce & ~hreset;
   assign w_beat   = bus.tvalid_s & w_tready;

   // Capture FSM: next state, count, flags and buffer write.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_done_nxt  = r_done;
      w_irq_nxt   = r_irq;
      w_trunc_nxt = r_trunc;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_count[AW-1:0];

      case (r_state)
         S_WAIT_SYNC: begin
            if (w_beat && bus.tuser_s) begin
               w_wr_en     = 1'b1;
               w_wr_idx    = '0;
               w_count_nxt = CW'(1);
               w_state_nxt = (bus.tlast_s && r_mode[1]) ? S_DONE : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_beat) begin
               w_wr_en     = 1'b1;
               w_count_nxt = r_count + CW'(1);
               if (w_count_nxt == CW'(DEPTH)) begin
                  w_trunc_nxt = 1'b1;
                  w_state_nxt = S_DONE;
               end
               if (bus.tlast_s && r_mode[1]) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: ;
      endcase

      // Control pulses override the beat-driven transition; ABORT has priority.
      if (r_abort) begin
         w_state_nxt = S_IDLE;
      end else if (r_arm && (r_state == S_IDLE || r_state == S_DONE)) begin
         w_state_nxt = r_mode[0] ? S_WAIT_SYNC : S_CAPTURE;
         w_count_nxt = '0;
         w_done_nxt  = 1'b0;
         w_trunc_nxt = 1'b0;
      end

      // Entry into DONE beats a simultaneous IRQ_CLR.
      if (w_state_nxt == S_DONE && r_state != S_DONE) begin
         w_done_nxt = 1'b1;
         w_irq_nxt  = 1'b1;
      end else if (r_irq_clr) begin
         w_irq_nxt = 1'b0;
      end
   end

   // Capture state registers; everything holds while ce is low.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
         r_irq   <= 1'b0;
         r_trunc <= 1'b0;
      end else if (ce) begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_done  <= w_done_nxt;
         r_irq   <= w_irq_nxt;
         r_trunc <= w_trunc_nxt;
      end
   end

   // Sample buffer: write port from the stream, synchronous read port for AHB.
   always_ff @(posedge hclk) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= bus.tdata_s;
      end
      if (w_addr_ph) begin
         r_ram_q <= r_mem[w_buf_idx];
      end
   end

   // AHB address-phase decode.
   assign w_addr_ph = bus.hsel_s & bus.hready_s & bus.htrans_s[1];
   assign w_buf_off = bus.haddr_s[11:2] - 10'd256;
   assign w_is_buf  = (bus.haddr_s[11:10] != 2'b00) && (11'(w_buf_off) < 11'(DEPTH));
   assign w_buf_idx = w_buf_off[AW-1:0];

   always_comb begin
      w_reg_rdata = '0;
      case (bus.haddr_s[11:0])
         A_MODE:   w_reg_rdata = 32'(r_mode);
         A_STATUS: w_reg_rdata = {27'd0, r_trunc, r_irq, r_done, r_state};
         A_COUNT:  w_reg_rdata = 32'(r_count);
         default:  w_reg_rdata = '0;
      endcase
   end

   assign w_wr_ctrl = r_dp_valid & r_dp_write & (r_dp_addr == A_CTRL);

   // AHB data phase: register reads zero-wait, buffer reads one wait state.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_dp_valid  <= 1'b0;
         r_dp_write  <= 1'b0;
         r_dp_addr   <= '0;
         r_rd_pend   <= 1'b0;
         r_hrdata    <= '0;
         r_hreadyout <= 1'b1;
         r_mode      <= '0;
         r_arm       <= 1'b0;
         r_abort     <= 1'b0;
         r_irq_clr   <= 1'b0;
      end else begin
         r_dp_valid <= w_addr_ph;
         if (w_addr_ph) begin
            r_dp_write <= bus.hwrite_s;
            r_dp_addr  <= bus.haddr_s[11:0];
         end

         r_rd_pend <= 1'b0;
         if (w_addr_ph && !bus.hwrite_s && w_is_buf) begin
            r_rd_pend   <= 1'b1;
            r_hreadyout <= 1'b0;
         end else if (r_rd_pend) begin
            r_hrdata    <= ext_sample(r_ram_q);
            r_hreadyout <= 1'b1;
         end else if (w_addr_ph && !bus.hwrite_s) begin
            r_hrdata    <= w_reg_rdata;
         end

         if (r_dp_valid && r_dp_write && r_dp_addr == A_MODE) begin
            r_mode <= bus.hwdata_s[1:0];
         end

         // Pulses stay pending until the capture logic is enabled to consume them.
         r_arm     <= (r_arm     & ~ce) | (w_wr_ctrl & bus.hwdata_s[0]);
         r_abort   <= (r_abort   & ~ce) | (w_wr_ctrl & bus.hwdata_s[1]);
         r_irq_clr <= (r_irq_clr & ~ce) | (w_wr_ctrl & bus.hwdata_s[2]);
      end
   end

   assign bus.tready_s    = w_tready;
   assign bus.hrdata_s    = r_hrdata;
   assign bus.hreadyout_s = r_hreadyout;
   assign bus.hresp_s     = 1'b0;
   assign irq             = r_irq;

   assign w_unused = ^{bus.haddr_s[31:12], bus.haddr_s[1:0], bus.htrans_s[0],
                       bus.hsize_s, bus.hburst_s, bus.hwdata_s[31:3]};
endmodule

// File: tb/tb_axis_capture_ahb.sv
// ---------------------------------------------------------------------------
// tb_axis_capture_ahb
// Purpose : self-checking bench for axis_capture_ahb. Directed sequence with
//           random sample data; expected values come from a transaction-level
//           model of the capture rules kept in this file.
// ---------------------------------------------------------------------------
module tb_axis_capture_ahb;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 256;

   logic hclk = 1'b0;
   logic hreset;
   logic ce;
   logic irq;
   int   errors = 0;
   int   checks = 0;

   axis_capture_ahb_if #(.DW(DW)) bus ();
   assign bus.hready_s = bus.hreadyout_s;

   axis_capture_ahb #(.DW(DW), .DEPTH(DEPTH)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .ce     (ce),
      .bus    (bus.slave),
      .irq    (irq)
   );

   always #5 hclk = ~hclk;

   // Model of the capture rules, updated once per accepted beat / control write.
   logic [15:0] m_mem [DEPTH];
   int          m_count;
   int          m_state;
   bit          m_done, m_irq, m_trunc;
   logic [1:0]  m_mode;

   function automatic void model_reset();
      m_count = 0; m_state = 0; m_done = 0; m_irq = 0; m_trunc = 0; m_mode = 2'd0;
   endfunction

   function automatic void model_enter_done();
      m_state = 3; m_done = 1; m_irq = 1;
   endfunction

   function automatic void model_ctrl(input logic [31:0] d);
      if (d[1]) m_state = 0;
      else if (d[0] && (m_state == 0 || m_state == 3)) begin
         m_state = m_mode[0] ? 1 : 2;
         m_count = 0; m_done = 0; m_trunc = 0;
      end
      if (d[2]) m_irq = 0;
   endfunction

   function automatic void model_beat(input logic [15:0] d, input bit last, input bit user);
      if (m_state == 1 && user) begin
         m_mem[0] = d;
         m_count  = 1;
         if (last && m_mode[1]) model_enter_done();
         else m_state = 2;
      end else if (m_state == 2) begin
         m_mem[m_count] = d;
         m_count++;
         if (m_count == DEPTH) m_trunc = 1;
         if (m_count == DEPTH || (last && m_mode[1])) model_enter_done();
      end
   endfunction

   function automatic logic [31:0] exp_status();
      return {27'd0, m_trunc, m_irq, m_done, 2'(m_state)};
   endfunction

   function automatic logic [31:0] exp_sample(input int i);
      logic [15:0] s;
      s = m_mem[i];
`ifdef AXIS_CAPTURE_SIGNED_EN
      return {{16{s[15]}}, s};
`else
      return {16'd0, s};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk); #1;
   endtask

   task automatic ahb_write(input logic [11:0] a, input logic [31:0] d);
      bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1;
      bus.haddr_s = {20'h0, a};
      tick();
      bus.hsel_s = 1'b0; bus.htrans_s = 2'b00; bus.hwrite_s = 1'b0;
      bus.hwdata_s = d;
      tick();
   endtask

   task automatic ahb_read(input logic [11:0] a, output logic [31:0] d, output int waits);
      bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b0;
      bus.haddr_s = {20'h0, a};
      tick();
      bus.hsel_s = 1'b0; bus.htrans_s = 2'b00;
      waits = 0;
      while (bus.hreadyout_s !== 1'b1 && waits < 8) begin
         waits++;
         tick();
      end
      d = bus.hrdata_s;
      tick();
   endtask

   task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp,
                           input int exp_waits);
      logic [31:0] d;
      int          w;
      ahb_read(a, d, w);
      check(tag, d, exp);
      check({tag, "_waits"}, 32'(w), 32'(exp_waits));
   endtask

   task automatic ctrl(input logic [31:0] d);
      ahb_write(12'h000, d);
      model_ctrl(d);
      tick();
   endtask

   task automatic set_mode(input logic [1:0] m);
      ahb_write(12'h004, 32'(m));
      m_mode = m;
   endtask

   task automatic beat(input logic [15:0] d, input bit last, input bit user);
      bus.tvalid_s = 1'b1; bus.tdata_s = d; bus.tlast_s = last; bus.tuser_s = user;
      tick();
      bus.tvalid_s = 1'b0; bus.tlast_s = 1'b0; bus.tuser_s = 1'b0;
      model_beat(d, last, user);
   endtask

   task automatic check_regs(input string tag);
      rd_check({tag, "_status"}, 12'h008, exp_status(), 0);
      rd_check({tag, "_count"},  12'h00C, 32'(m_count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int idx;
      hreset = 1'b1; ce = 1'b1;
      bus.tdata_s = '0; bus.tvalid_s = 1'b0; bus.tlast_s = 1'b0; bus.tuser_s = 1'b0;
      bus.haddr_s = '0; bus.htrans_s = 2'b00; bus.hsize_s = 3'b010; bus.hburst_s = 3'b000;
      bus.hwrite_s = 1'b0; bus.hwdata_s = '0; bus.hsel_s = 1'b0;
      model_reset();

      // Reset state
      tick(); tick();
      check("rst_tready",    32'(bus.tready_s),    32'd0);
      check("rst_hreadyout", 32'(bus.hreadyout_s), 32'd1);
      check("rst_hrdata",    bus.hrdata_s,         32'd0);
      check("rst_hresp",     32'(bus.hresp_s),     32'd0);
      check("rst_irq",       32'(irq),             32'd0);
      hreset = 1'b0;
      #1;
      check("post_rst_tready", 32'(bus.tready_s), 32'd1);
      tick();
      check_regs("rst");
      rd_check("rst_mode", 12'h004, 32'd0, 0);

      // Free-running capture until the buffer fills
      set_mode(2'd0);
      ctrl(32'h1);
      check_regs("armed0");
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("irq_before_last", 32'(irq), 32'd0);
         beat(16'(i + 1), 1'b0, 1'b0);
      end
      check("irq_after_full", 32'(irq), 32'd1);
      check_regs("full");
      rd_check("full_s255", 12'h7FC, 32'h0000_0100, 1);
      check("full_s255_model", exp_sample(255), 32'h0000_0100);
      for (int k = 0; k < 3; k++) begin
         idx = int'($urandom_range(0, DEPTH - 1));
         rd_check("full_rand", 12'(12'h400 + 4 * idx), exp_sample(idx), 1);
      end
      // A beat while DONE is accepted and dropped
      bus.tvalid_s = 1'b1; bus.tdata_s = 16'h5555;
      #1;
      check("done_tready", 32'(bus.tready_s), 32'd1);
      @(posedge hclk); #1;
      bus.tvalid_s = 1'b0;
      rd_check("done_count", 12'h00C, 32'(m_count), 0);
      // Odd addresses
      rd_check("ctrl_read",  12'h000, 32'd0, 0);
      rd_check("unmapped",   12'h010, 32'd0, 0);
      rd_check("past_depth", 12'h800, 32'd0, 0);
      ahb_write(12'h400, 32'hFFFF);
      ahb_write(12'h020, 32'h3);
      rd_check("bufwr_ignored", 12'h400, exp_sample(0), 1);
      rd_check("mode_after_unmapped_wr", 12'h004, 32'd0, 0);

      // IRQ clear
      ctrl(32'h4);
      check("irq_cleared", 32'(irq), 32'd0);
      check_regs("irqclr");

      // STOP_ON_LAST; a beat in the cycle ARM takes effect sees the old state
      set_mode(2'd2);
      ahb_write(12'h000, 32'h1);
      beat(16'hDEAD, 1'b0, 1'b0);
      model_ctrl(32'h1);
      for (int i = 0; i < 10; i++) beat(16'($urandom), i == 9, 1'b0);
      check("irq_after_last", 32'(irq), 32'd1);
      bus.tvalid_s = 1'b1; bus.tdata_s = 16'h7777; bus.tlast_s = 1'b1;
      #1;
      check("beat11_tready", 32'(bus.tready_s), 32'd1);
      @(posedge hclk); #1;
      bus.tvalid_s = 1'b0; bus.tlast_s = 1'b0;
      check_regs("last");
      for (int i = 0; i <= 10; i++) rd_check("last_smp", 12'(12'h400 + 4 * i), exp_sample(i), 1);

      // SYNC start, then ABORT after 20 samples
      set_mode(2'd1);
      ctrl(32'h5);
      check_regs("wait_sync");
      for (int i = 0; i < 5; i++) beat(16'($urandom), 1'b0, 1'b0);
      check_regs("still_wait");
      beat(16'h00AB, 1'b0, 1'b1);
      for (int i = 0; i < 19; i++) beat(16'($urandom), 1'b0, 1'b0);
      check_regs("sync_cap");
      ctrl(32'h2);
      check_regs("abort");
      check("abort_irq", 32'(irq), 32'd0);
      rd_check("sync_s0", 12'h400, 32'h0000_00AB, 1);
      rd_check("sync_s0_model", 12'h400, exp_sample(0), 1);

      // Sample extension, clock-enable hold, ARM+ABORT together
      set_mode(2'd0);
      ctrl(32'h1);
      beat(16'h8000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) beat(16'($urandom), 1'b0, 1'b0);
      ce = 1'b0;
      bus.tvalid_s = 1'b1; bus.tdata_s = 16'h1234;
      #1;
      check("ce_low_tready", 32'(bus.tready_s), 32'd0);
      tick(); tick();
      bus.tvalid_s = 1'b0;
      ce = 1'b1;
      check_regs("ce_hold");
`ifdef AXIS_CAPTURE_SIGNED_EN
      rd_check("ext_8000", 12'h400, 32'hFFFF_8000, 1);
`else
      rd_check("ext_8000", 12'h400, 32'h0000_8000, 1);
`endif
      for (int i = 1; i < 5; i++) rd_check("cap_smp", 12'(12'h400 + 4 * i), exp_sample(i), 1);
      ctrl(32'h3);
      check_regs("arm_abort");

      // Reset in the middle of a capture with irq pending
      set_mode(2'd2);
      ctrl(32'h1);
      for (int i = 0; i < 3; i++) beat(16'($urandom), i == 2, 1'b0);
      set_mode(2'd0);
      ctrl(32'h1);
      for (int i = 0; i < 30; i++) beat(16'($urandom), 1'b0, 1'b0);
      check_regs("pre_reset");
      check("pre_reset_irq", 32'(irq), 32'd1);
      hreset = 1'b1;
      #1;
      check("in_reset_tready", 32'(bus.tready_s), 32'd0);
      @(posedge hclk); #1;
      hreset = 1'b0;
      model_reset();
      check("reset_irq", 32'(irq), 32'd0);
      check_regs("mid_reset");
      rd_check("mid_reset_mode", 12'h004, 32'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
